// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset main controller: Moore FSM that sequences fetch, decode,
// execute, memory and write-back, with optional memory handshake on FETCH/MEMRD/MEMWR.
module multicycle_ctrl #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int ALUCTL_W      = 3,
  parameter int EN_JAL        = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          Opcode,
  input  logic [5:0]          Funct,
  input  logic                mem_ready,
  output logic                IorD,
  output logic                ALUSrcA,
  output logic                IRWrite,
  output logic                MemWrite,
  output logic                PCWrite,
  output logic                RegWrite,
  output logic                Ori,
  output logic                Branch,
  output logic                BranchNE,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSrc,
  output logic [1:0]          MemtoReg,
  output logic [1:0]          RegDst,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic [3:0]          state_o,
  output logic                trap
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_EXEC_I = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13,
    S_TRAP   = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  state_t     r_state;
  state_t     w_next;
  logic       r_ori;
  logic       w_mr;
  logic [3:0] w_alu_r;
  logic [4:0] w_alu_i;

  logic       w_iord, w_srca, w_irw, w_memw, w_pcw, w_regw, w_ori, w_br, w_bne, w_trap;
  logic [1:0] w_srcb, w_pcsrc, w_m2r, w_rdst;
  logic [2:0] w_alu;

  // R-type function decode: {legal, ALU control}
  function automatic logic [3:0] f_alu_r(input logic [5:0] fn);
    case (fn)
      FN_ADD:  f_alu_r = {1'b1, ALU_ADD};
      FN_SUB:  f_alu_r = {1'b1, ALU_SUB};
      FN_AND:  f_alu_r = {1'b1, ALU_AND};
      FN_OR:   f_alu_r = {1'b1, ALU_OR};
      FN_SLT:  f_alu_r = {1'b1, ALU_SLT};
      default: f_alu_r = {1'b0, ALU_ADD};
    endcase
  endfunction

  // Immediate-op decode: {legal, zero-extend, ALU control}
  function automatic logic [4:0] f_alu_i(input logic [5:0] op);
    case (op)
      OP_ADDI: f_alu_i = {1'b1, 1'b0, ALU_ADD};
      OP_ANDI: f_alu_i = {1'b1, 1'b1, ALU_AND};
      OP_ORI:  f_alu_i = {1'b1, 1'b1, ALU_OR};
      default: f_alu_i = {1'b0, 1'b0, ALU_ADD};
    endcase
  endfunction

  function automatic state_t f_decode(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_LW, OP_SW:              f_decode = S_MEMADR;
      OP_RTYPE:                  f_decode = (fn == FN_JR) ? S_JR : S_EXEC_R;
      OP_BEQ, OP_BNE:            f_decode = S_BRANCH;
      OP_ADDI, OP_ANDI, OP_ORI:  f_decode = S_EXEC_I;
      OP_J:                      f_decode = S_JUMP;
      OP_JAL:                    f_decode = (EN_JAL != 0) ? S_JAL : S_TRAP;
      default:                   f_decode = S_TRAP;
    endcase
  endfunction

  assign w_mr    = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign w_alu_r = f_alu_r(Funct);
  assign w_alu_i = f_alu_i(Opcode);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_ori   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_EXEC_I) r_ori <= w_alu_i[3];
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = w_mr ? S_DECODE : S_FETCH;
      S_DECODE: w_next = f_decode(Opcode, Funct);
      S_MEMADR: w_next = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = w_mr ? S_MEMWB : S_MEMRD;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = w_mr ? S_FETCH : S_MEMWR;
      S_EXEC_R: w_next = w_alu_r[3] ? S_ALUWB : S_TRAP;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_EXEC_I: w_next = w_alu_i[4] ? S_IWB : S_TRAP;
      S_IWB:    w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_JAL:    w_next = S_FETCH;
      S_JR:     w_next = S_FETCH;
      S_TRAP:   w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  // Moore output decode; only the memory-side strobes see the handshake
  always_comb begin
    w_iord  = 1'b0;
    w_srca  = 1'b0;
    w_irw   = 1'b0;
    w_memw  = 1'b0;
    w_pcw   = 1'b0;
    w_regw  = 1'b0;
    w_ori   = 1'b0;
    w_br    = 1'b0;
    w_bne   = 1'b0;
    w_trap  = 1'b0;
    w_srcb  = 2'b00;
    w_pcsrc = 2'b00;
    w_m2r   = 2'b00;
    w_rdst  = 2'b00;
    w_alu   = 3'b000;
    case (r_state)
      S_FETCH: begin
        w_srcb = 2'b01;
        w_alu  = ALU_ADD;
        w_irw  = w_mr;
        w_pcw  = w_mr;
      end
      S_DECODE: begin
        w_srcb = 2'b11;
        w_alu  = ALU_ADD;
      end
      S_MEMADR: begin
        w_srca = 1'b1;
        w_srcb = 2'b10;
        w_alu  = ALU_ADD;
      end
      S_MEMRD: w_iord = 1'b1;
      S_MEMWB: begin
        w_m2r  = 2'b01;
        w_regw = 1'b1;
      end
      S_MEMWR: begin
        w_iord = 1'b1;
        w_memw = w_mr;
      end
      S_EXEC_R: begin
        w_srca = 1'b1;
        w_alu  = w_alu_r[2:0];
      end
      S_ALUWB: begin
        w_rdst = 2'b01;
        w_regw = 1'b1;
      end
      S_BRANCH: begin
        w_srca  = 1'b1;
        w_alu   = ALU_SUB;
        w_pcsrc = 2'b01;
        w_br    = (Opcode == OP_BEQ);
        w_bne   = (Opcode == OP_BNE);
      end
      S_EXEC_I: begin
        w_srca = 1'b1;
        w_srcb = 2'b10;
        w_alu  = w_alu_i[2:0];
        w_ori  = w_alu_i[3];
      end
      S_IWB: begin
        w_regw = 1'b1;
        w_ori  = r_ori;
      end
      S_JUMP: begin
        w_pcsrc = 2'b10;
        w_pcw   = 1'b1;
      end
      S_JAL: begin
        w_pcsrc = 2'b10;
        w_pcw   = 1'b1;
        w_rdst  = 2'b10;
        w_m2r   = 2'b10;
        w_regw  = 1'b1;
      end
      S_JR: begin
        w_pcsrc = 2'b11;
        w_pcw   = 1'b1;
      end
      S_TRAP:  w_trap = 1'b1;
      default: w_trap = 1'b0;
    endcase
  end

  // Reset forces every output quiet, independent of the registered state
  assign IorD       = rst ? 1'b0 : w_iord;
  assign ALUSrcA    = rst ? 1'b0 : w_srca;
  assign IRWrite    = rst ? 1'b0 : w_irw;
  assign MemWrite   = rst ? 1'b0 : w_memw;
  assign PCWrite    = rst ? 1'b0 : w_pcw;
  assign RegWrite   = rst ? 1'b0 : w_regw;
  assign Ori        = rst ? 1'b0 : w_ori;
  assign Branch     = rst ? 1'b0 : w_br;
  assign BranchNE   = rst ? 1'b0 : w_bne;
  assign ALUSrcB    = rst ? 2'b00 : w_srcb;
  assign PCSrc      = rst ? 2'b00 : w_pcsrc;
  assign MemtoReg   = rst ? 2'b00 : w_m2r;
  assign RegDst     = rst ? 2'b00 : w_rdst;
  assign ALUControl = rst ? '0 : ALUCTL_W'(w_alu);
  assign state_o    = rst ? 4'd0 : 4'(r_state);
  assign trap       = rst ? 1'b0 : w_trap;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 1; 1 = fetch/load/store states wait on mem_ready, 0 = mem_ready ignored (treated as 1).
REQ-002 SHALL have parameter ALUCTL_W, default 3; width of ALUControl (>=3; upper bits zero).
REQ-003 SHALL have parameter EN_JAL, default 1; 0 = jal treated as illegal opcode.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 Opcode  input  6  instruction[31:26]; Funct  input  6  instruction[5:0].
REQ-007 mem_ready  input  1  memory access completes this cycle.
REQ-008 IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, RegWrite, Ori, Branch, BranchNE  output  1 each: address select, A-operand select, IR load, mem write, unconditional PC load, RF write, zero-extend immediate, beq enable, bne enable.
REQ-009 ALUSrcB  output  2  00 reg B, 01 const 4, 10 ext imm, 11 imm<<2; PCSrc  output  2  00 ALUResult, 01 ALUOut, 10 jump target, 11 reg A (jr).
REQ-010 MemtoReg  output  2  00 ALUOut, 01 mem data, 10 PC; RegDst  output  2  00 rt, 01 rd, 10 const 31.
REQ-011 ALUControl  output  ALUCTL_W  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-012 state_o  output  4  current state code; trap  output  1  illegal-instruction pulse.

Function
REQ-013 States/codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC_R 6, ALUWB 7, BRANCH 8, EXEC_I 9, IWB 10, JUMP 11, JAL 12, JR 13, TRAP 14; code 15 unreachable, SHALL go to FETCH.
REQ-014 Outputs Moore-decoded from state; only IRWrite, PCWrite, MemWrite additionally gated by effective mem_ready; unlisted outputs 0.
REQ-015 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=add, PCSrc=00; IRWrite=PCWrite=mem_ready; stay while !mem_ready, else DECODE.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=add (branch target to ALUOut); next by Opcode: 100011/101011 MEMADR, 000000 EXEC_R (Funct 001000 JR), 000100/000101 BRANCH, 001000/001100/001101 EXEC_I, 000010 JUMP, 000011 JAL (if EN_JAL), else TRAP.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, add; next MEMRD (lw) or MEMWR (sw).
REQ-018 MEMRD: IorD=1; wait on mem_ready, then MEMWB. MEMWB: RegDst=00, MemtoReg=01, RegWrite=1; next FETCH.
REQ-019 MEMWR: IorD=1, MemWrite=mem_ready; wait on mem_ready, then FETCH.
REQ-020 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUControl by Funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; other Funct SHALL go to TRAP instead of ALUWB.
REQ-021 ALUWB: RegDst=01, MemtoReg=00, RegWrite=1; next FETCH.
REQ-022 BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01; Branch=1 for 000100, BranchNE=1 for 000101; next FETCH.
REQ-023 EXEC_I: ALUSrcA=1, ALUSrcB=10; addi add/Ori=0; andi and/Ori=1; ori or/Ori=1; next IWB. IWB: RegDst=00, MemtoReg=00, RegWrite=1, Ori held as in EXEC_I; next FETCH.
REQ-024 JUMP: PCSrc=10, PCWrite=1; next FETCH. JAL: PCSrc=10, PCWrite=1, RegDst=10, MemtoReg=10, RegWrite=1; next FETCH. JR: PCSrc=11, PCWrite=1; next FETCH.
REQ-025 TRAP: trap=1 for exactly one cycle, no writes; next FETCH.
REQ-026 Zero-wait latencies (FETCH..last state): R 4, addi/andi/ori 4, lw 5, sw 4, beq/bne 3, j/jal/jr 3 cycles; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one.
REQ-027 Opcode/Funct sampled only in DECODE/EXEC_R/EXEC_I/MEMADR/BRANCH; changes elsewhere SHALL have no effect.

Reset
REQ-028 rst=1 at a rising edge SHALL load FETCH regardless of state, including mid-wait in MEMRD/MEMWR.
REQ-029 While rst=1 all outputs SHALL be 0 and state_o=0; first cycle after release is FETCH with normal decode.

Verification
REQ-030 Reset mid-MEMWR (mem_ready=0): assert rst 1 cycle -> MemWrite never 1; next cycle state_o=0, IRWrite=0 until mem_ready=1.
REQ-031 lw, mem_ready=1 always -> state_o 0,1,2,3,4,0; RegWrite=1, MemtoReg=01 only in state 4.
REQ-032 R add with mem_ready=0 for 2 FETCH cycles -> IRWrite/PCWrite low 2 cycles then high 1; ALUControl=010 in EXEC_R; RegDst=01 in ALUWB.
REQ-033 bne (000101) -> BRANCH with BranchNE=1, Branch=0, ALUControl=110, PCSrc=01.
REQ-034 jal with EN_JAL=1 -> JAL: RegDst=10, MemtoReg=10, PCSrc=10; with EN_JAL=0 -> TRAP, trap pulses 1 cycle.
REQ-035 Opcode 111111 and R-type Funct 000111 -> each reaches TRAP, no RegWrite/MemWrite/PCWrite, returns to FETCH.
